// File: rtl/oursring_resp_xbar_pkg.sv
// Shared types and helpers for the ring-station response crossbar.
package oursring_resp_xbar_pkg;

  // Arbitration policy applied independently by every output arbiter.
  typedef enum logic {
    ARB_RR = 1'b0,  // round-robin, pointer advances past the accepted input
    ARB_FP = 1'b1   // fixed priority, lowest input index wins
  } arb_mode_e;

  // Upper bound on N_IN / N_OUT; helpers below work on vectors of this width.
  localparam int MAX_PORTS = 8;

  // Keep only the lowest set bit of a destination match vector.
  function automatic logic [MAX_PORTS-1:0] lowest_onehot(input logic [MAX_PORTS-1:0] vec);
    return vec & (~vec + 1'b1);
  endfunction

endpackage

// File: rtl/oursring_resp_xbar_port.sv
// One output port, one channel: arbiter across all inputs, optional burst
// lock (R channel), and the output FIFO whose head drives the ring.
module oursring_resp_xbar_port
  import oursring_resp_xbar_pkg::*;
#(
  parameter int        N_IN     = 3,
  parameter int        WIDTH    = 16,
  parameter int        DEPTH    = 2,
  parameter int        LAST_POS = 0,
  parameter bit        LOCK_EN  = 1'b0,
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       valid_i,
  input  logic [N_IN-1:0]       match_i,
  input  logic [N_IN*WIDTH-1:0] data_i,
  output logic [N_IN-1:0]       ready_o,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      data_o,
  input  logic                  ready_i,
  output logic                  busy_o
);

  localparam int          IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [N_IN-1:0]  cand;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] ptr_q, owner_q;
  logic             lock_q;
  logic [AW:0]      cnt_q;
  logic [AW-1:0]    wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] push_data;
  logic             can_push, push, pop;

  // Pick the winning input: restrict to the lock owner, then search from the
  // RR pointer (or from index 0 in fixed-priority mode).
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int idx;
    idx     = 0;
    cand    = valid_i & match_i;
    if (LOCK_EN && lock_q) cand = cand & (N_IN'(1) << owner_q);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx = (ARB_MODE == ARB_RR) ? (int'(ptr_q) + k) % N_IN : k;
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  assign push_data = data_i[gnt_idx*WIDTH +: WIDTH];
  assign valid_o   = (cnt_q != '0);
  assign data_o    = mem_q[rd_q];
  assign pop       = valid_o & ready_i;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign can_push  = (cnt_q != CNT_FULL) || pop;
  assign push      = gnt_vld & can_push & ~rst;
  assign ready_o   = push ? (N_IN'(1) << gnt_idx) : '0;
  assign busy_o    = valid_o | lock_q;

  // FIFO pointers, occupancy, RR pointer and burst lock.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      if (push && ARB_MODE == ARB_RR) ptr_q <= IDX_W'((int'(gnt_idx) + 1) % N_IN);
      if (LOCK_EN && push) begin
        lock_q  <= ~push_data[LAST_POS];
        owner_q <= gnt_idx;
      end
    end
  end

  // Payload storage.
  // NOTE: storage is deliberately not reset; occupancy alone decides what is
  // valid, so stale entries are never observable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/oursring_resp_xbar.sv
// N_IN x N_OUT response crossbar for the ring station (B and R channels),
// with an unmatched-destination sink and a busy flag for clock gating.
module oursring_resp_xbar
  import oursring_resp_xbar_pkg::*;
#(
  parameter int N_IN      = 3,
  parameter int N_OUT     = 3,
  parameter int B_W       = 16,
  parameter int R_W       = 80,
  parameter int RLAST_POS = 0,
  parameter int OUT_DEPTH = 2,
  parameter int ARB_MODE  = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       i_bvalid,
  input  logic [N_IN*B_W-1:0]   i_b,
  output logic [N_IN-1:0]       i_bready,
  input  logic [N_IN-1:0]       i_rvalid,
  input  logic [N_IN*R_W-1:0]   i_r,
  output logic [N_IN-1:0]       i_rready,
  input  logic [N_IN*N_OUT-1:0] is_b_dst_match,
  input  logic [N_IN*N_OUT-1:0] is_r_dst_match,
  output logic [N_OUT-1:0]      o_bvalid,
  output logic [N_OUT*B_W-1:0]  o_b,
  input  logic [N_OUT-1:0]      o_bready,
  output logic [N_OUT-1:0]      o_rvalid,
  output logic [N_OUT*R_W-1:0]  o_r,
  input  logic [N_OUT-1:0]      o_rready,
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic                  err_sticky,
  output logic                  o_busy
);

  localparam arb_mode_e ARB    = (ARB_MODE == 0) ? ARB_RR : ARB_FP;
  localparam int        DROP_W = $clog2(2 * MAX_PORTS + 1);
  localparam int        SUM_W  = ERR_CNT_W + DROP_W;

  logic [N_IN-1:0]      b_drop, r_drop;
  logic [N_IN-1:0]      b_col [N_OUT];
  logic [N_IN-1:0]      r_col [N_OUT];
  logic [N_IN-1:0]      b_rdy [N_OUT];
  logic [N_IN-1:0]      r_rdy [N_OUT];
  logic [N_OUT-1:0]     b_busy, r_busy;
  logic [DROP_W-1:0]    drop_n;
  logic [SUM_W-1:0]     err_sum;
  logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
  logic                 err_sticky_d, err_sticky_q;

  // Reduce each input's match vector to its lowest destination and transpose
  // into one candidate column per output; valid beats with no match drop.
  always_comb begin : match_mask
    logic [MAX_PORTS-1:0] b_oh, r_oh;
    b_oh   = '0;
    r_oh   = '0;
    b_drop = '0;
    r_drop = '0;
    for (int j = 0; j < N_OUT; j++) begin
      b_col[j] = '0;
      r_col[j] = '0;
    end
    for (int i = 0; i < N_IN; i++) begin
      b_oh      = lowest_onehot(MAX_PORTS'(is_b_dst_match[i*N_OUT +: N_OUT]));
      r_oh      = lowest_onehot(MAX_PORTS'(is_r_dst_match[i*N_OUT +: N_OUT]));
      b_drop[i] = i_bvalid[i] & ~|b_oh;
      r_drop[i] = i_rvalid[i] & ~|r_oh;
      for (int j = 0; j < N_OUT; j++) begin
        b_col[j][i] = b_oh[j];
        r_col[j][i] = r_oh[j];
      end
    end
  end

  // An input is ready if any output accepted it, or if the sink swallows it.
  always_comb begin
    i_bready = b_drop;
    i_rready = r_drop;
    for (int j = 0; j < N_OUT; j++) begin
      i_bready = i_bready | b_rdy[j];
      i_rready = i_rready | r_rdy[j];
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    oursring_resp_xbar_port #(
      .N_IN(N_IN), .WIDTH(B_W), .DEPTH(OUT_DEPTH), .LAST_POS(0),
      .LOCK_EN(1'b0), .ARB_MODE(ARB)
    ) u_b (
      .clk, .rst,
      .valid_i(i_bvalid), .match_i(b_col[j]), .data_i(i_b), .ready_o(b_rdy[j]),
      .valid_o(o_bvalid[j]), .data_o(o_b[j*B_W +: B_W]), .ready_i(o_bready[j]),
      .busy_o(b_busy[j])
    );

    oursring_resp_xbar_port #(
      .N_IN(N_IN), .WIDTH(R_W), .DEPTH(OUT_DEPTH), .LAST_POS(RLAST_POS),
      .LOCK_EN(1'b1), .ARB_MODE(ARB)
    ) u_r (
      .clk, .rst,
      .valid_i(i_rvalid), .match_i(r_col[j]), .data_i(i_r), .ready_o(r_rdy[j]),
      .valid_o(o_rvalid[j]), .data_o(o_r[j*R_W +: R_W]), .ready_i(o_rready[j]),
      .busy_o(r_busy[j])
    );
  end

  // Count this cycle's drops across both channels and saturate; clear wins.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < N_IN; i++) begin
      drop_n = drop_n + DROP_W'(b_drop[i]) + DROP_W'(r_drop[i]);
    end
    err_sum = SUM_W'(err_cnt_q) + SUM_W'(drop_n);
    if (err_clr)                            err_cnt_d = '0;
    else if (|err_sum[SUM_W-1:ERR_CNT_W])   err_cnt_d = '1;
    else                                    err_cnt_d = err_sum[ERR_CNT_W-1:0];
    err_sticky_d = err_clr ? 1'b0 : (err_sticky_q | (|drop_n));
  end

  // Error counter and sticky flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;
  assign o_busy     = |{b_busy, r_busy};

endmodule

// File: tb/tb_oursring_resp_xbar.sv
// Self-checking bench for oursring_resp_xbar (3x3, depth 2): directed
// sequences, a routing vector table, and randomized traffic against a
// queue-based reference model. A second instance runs fixed priority.
module tb_oursring_resp_xbar;

  localparam int NI = 3, NO = 3, BW = 16, RW = 80, DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] i_bvalid = '0, i_rvalid = '0;
  logic [NI*BW-1:0] i_b = '0;
  logic [NI*RW-1:0] i_r = '0;
  logic [NI*NO-1:0] bmatch = '0, rmatch = '0;
  logic [NO-1:0] o_bready = '0, o_rready = '0;
  logic          err_clr = 1'b0;

  logic [NI-1:0] i_bready, i_rready, fp_i_bready, fp_i_rready;
  logic [NO-1:0] o_bvalid, o_rvalid, fp_o_bvalid, fp_o_rvalid;
  logic [NO*BW-1:0] o_b, fp_o_b;
  logic [NO*RW-1:0] o_r, fp_o_r;
  logic [7:0]    err_cnt, fp_err_cnt;
  logic          err_sticky, fp_err_sticky, o_busy, fp_o_busy;

  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  oursring_resp_xbar #(
    .N_IN(NI), .N_OUT(NO), .B_W(BW), .R_W(RW), .RLAST_POS(0),
    .OUT_DEPTH(DEPTH), .ARB_MODE(0), .ERR_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_bvalid(i_bvalid), .i_b(i_b), .i_bready(i_bready),
    .i_rvalid(i_rvalid), .i_r(i_r), .i_rready(i_rready),
    .is_b_dst_match(bmatch), .is_r_dst_match(rmatch),
    .o_bvalid(o_bvalid), .o_b(o_b), .o_bready(o_bready),
    .o_rvalid(o_rvalid), .o_r(o_r), .o_rready(o_rready),
    .err_clr(err_clr), .err_cnt(err_cnt), .err_sticky(err_sticky), .o_busy(o_busy)
  );

  oursring_resp_xbar #(
    .N_IN(NI), .N_OUT(NO), .B_W(BW), .R_W(RW), .RLAST_POS(0),
    .OUT_DEPTH(DEPTH), .ARB_MODE(1), .ERR_CNT_W(8)
  ) dut_fp (
    .clk(clk), .rst(rst),
    .i_bvalid(i_bvalid), .i_b(i_b), .i_bready(fp_i_bready),
    .i_rvalid(i_rvalid), .i_r(i_r), .i_rready(fp_i_rready),
    .is_b_dst_match(bmatch), .is_r_dst_match(rmatch),
    .o_bvalid(fp_o_bvalid), .o_b(fp_o_b), .o_bready(o_bready),
    .o_rvalid(fp_o_rvalid), .o_r(fp_o_r), .o_rready(o_rready),
    .err_clr(err_clr), .err_cnt(fp_err_cnt), .err_sticky(fp_err_sticky), .o_busy(fp_o_busy)
  );

  typedef logic [BW-1:0] bq_t [$];
  typedef logic [RW-1:0] rq_t [$];

  typedef struct {
    int         src;
    logic [2:0] match;
    int         dst;   // -1 = no destination, beat goes to the sink
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_bvalid = '0;
    i_rvalid = '0;
    err_clr  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    o_bready = '0;
    o_rready = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [RW-1:0] mk_r(input int id, input int n, input bit last);
    return {8'(id), 71'(n), last};
  endfunction

  // Destination index from a raw match vector: lowest set bit, -1 if none.
  function automatic int dst_of(input logic [2:0] m);
    for (int j = 0; j < NO; j++) if (m[j]) return j;
    return -1;
  endfunction

  // ---------------- randomized test with reference model -----------------
  task automatic random_test(input int cycles);
    bq_t mbq [NO];
    rq_t mrq [NO];
    int bptr [NO], rptr [NO], rown [NO], gb [NO], gr [NO];
    bit cpb [NO], cpr [NO];
    int merr;
    bit msticky, exp_busy;
    logic [NI-1:0] eb, er, acc_b, acc_r, in_burst;
    int drops;

    do_reset();
    for (int j = 0; j < NO; j++) begin
      mbq[j].delete(); mrq[j].delete();
      bptr[j] = 0; rptr[j] = 0; rown[j] = -1;
    end
    merr = 0; msticky = 0;
    acc_b = '0; acc_r = '0; in_burst = '0;

    for (int c = 0; c < cycles; c++) begin
      // New stimulus only where the previous beat was taken or nothing was offered.
      for (int i = 0; i < NI; i++) begin
        if (!i_bvalid[i] || acc_b[i]) begin
          i_bvalid[i]       = ($urandom_range(0, 2) != 0);
          i_b[i*BW +: BW]   = 16'($urandom);
          bmatch[i*NO +: NO] = 3'($urandom_range(0, 7));
        end
        if (!i_rvalid[i] || acc_r[i]) begin
          i_rvalid[i]     = ($urandom_range(0, 2) != 0);
          i_r[i*RW +: RW] = {8'($urandom), 32'($urandom), 32'($urandom), 7'($urandom),
                             1'($urandom_range(0, 1))};
          if (!in_burst[i]) rmatch[i*NO +: NO] = 3'($urandom_range(0, 7));
        end
      end
      for (int j = 0; j < NO; j++) begin
        o_bready[j] = ($urandom_range(0, 3) != 0);
        o_rready[j] = ($urandom_range(0, 3) != 0);
      end
      err_clr = ($urandom_range(0, 63) == 0);
      #1;

      // Expected handshakes from the arbitration rules.
      eb = '0; er = '0;
      for (int j = 0; j < NO; j++) begin
        gb[j] = -1; gr[j] = -1;
        for (int k = 0; k < NI; k++) begin
          int i;
          i = (bptr[j] + k) % NI;
          if (gb[j] < 0 && i_bvalid[i] && dst_of(bmatch[i*NO +: NO]) == j) gb[j] = i;
          i = (rptr[j] + k) % NI;
          if (gr[j] < 0 && i_rvalid[i] && dst_of(rmatch[i*NO +: NO]) == j &&
              (rown[j] < 0 || rown[j] == i)) gr[j] = i;
        end
        cpb[j] = (mbq[j].size() < DEPTH) || o_bready[j];
        cpr[j] = (mrq[j].size() < DEPTH) || o_rready[j];
        if (gb[j] >= 0 && cpb[j]) eb[gb[j]] = 1'b1;
        if (gr[j] >= 0 && cpr[j]) er[gr[j]] = 1'b1;
      end
      drops = 0;
      for (int i = 0; i < NI; i++) begin
        if (i_bvalid[i] && dst_of(bmatch[i*NO +: NO]) < 0) begin eb[i] = 1'b1; drops++; end
        if (i_rvalid[i] && dst_of(rmatch[i*NO +: NO]) < 0) begin er[i] = 1'b1; drops++; end
      end

      // Compare DUT against the model.
      check("rnd_i_bready", i_bready, eb);
      check("rnd_i_rready", i_rready, er);
      exp_busy = 0;
      for (int j = 0; j < NO; j++) begin
        check("rnd_o_bvalid", o_bvalid[j], mbq[j].size() > 0);
        check("rnd_o_rvalid", o_rvalid[j], mrq[j].size() > 0);
        if (mbq[j].size() > 0) check("rnd_o_b", o_b[j*BW +: BW], mbq[j][0]);
        if (mrq[j].size() > 0) check("rnd_o_r", o_r[j*RW +: RW], mrq[j][0]);
        if (mbq[j].size() > 0 || mrq[j].size() > 0 || rown[j] >= 0) exp_busy = 1;
      end
      check("rnd_err_cnt", err_cnt, merr);
      check("rnd_err_sticky", err_sticky, msticky);
      check("rnd_o_busy", o_busy, exp_busy);

      // Advance the model across the clock edge.
      for (int j = 0; j < NO; j++) begin
        if (mbq[j].size() > 0 && o_bready[j]) void'(mbq[j].pop_front());
        if (mrq[j].size() > 0 && o_rready[j]) void'(mrq[j].pop_front());
        if (gb[j] >= 0 && cpb[j]) begin
          mbq[j].push_back(i_b[gb[j]*BW +: BW]);
          bptr[j] = (gb[j] + 1) % NI;
        end
        if (gr[j] >= 0 && cpr[j]) begin
          mrq[j].push_back(i_r[gr[j]*RW +: RW]);
          rptr[j] = (gr[j] + 1) % NI;
          rown[j] = i_r[gr[j]*RW] ? -1 : gr[j];
        end
      end
      if (err_clr) begin
        merr = 0; msticky = 0;
      end else begin
        merr = (merr + drops > 255) ? 255 : merr + drops;
        if (drops > 0) msticky = 1;
      end
      acc_b = eb & i_bvalid;
      acc_r = er & i_rvalid;
      for (int i = 0; i < NI; i++) if (acc_r[i]) in_burst[i] = ~i_r[i*RW];
      @(posedge clk);
      #1;
    end
    idle();
  endtask

  // ------------------------------ main flow -------------------------------
  initial begin
    vec_t vecs [8];
    logic [BW-1:0] exp_b, pay;
    logic [2:0] exp_g;
    logic a0, a2;
    int merr, beat, acc;
    rq_t seen, expq;

    vecs[0] = '{0, 3'b001, 0};
    vecs[1] = '{1, 3'b010, 1};
    vecs[2] = '{2, 3'b100, 2};
    vecs[3] = '{0, 3'b110, 1};
    vecs[4] = '{1, 3'b111, 0};
    vecs[5] = '{2, 3'b000, -1};
    vecs[6] = '{1, 3'b101, 0};
    vecs[7] = '{0, 3'b000, -1};

    // Reset state, with valid traffic present; in2 B has no destination.
    rst = 1'b1;
    i_bvalid = '1; i_rvalid = '1;
    bmatch = {3'b000, 3'b001, 3'b001};
    rmatch = {3'b001, 3'b001, 3'b001};
    tick();
    check("rst_o_bvalid", o_bvalid, 0);
    check("rst_o_rvalid", o_rvalid, 0);
    check("rst_o_busy", o_busy, 0);
    check("rst_i_bready_sink_only", i_bready, 3'b100);
    check("rst_i_rready", i_rready, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_sticky", err_sticky, 0);

    // RR: three inputs stream B to out 0; grants rotate 0,1,2,...
    do_reset();
    o_bready = '1;
    for (int i = 0; i < NI; i++) begin
      i_bvalid[i] = 1'b1;
      bmatch[i*NO +: NO] = 3'b001;
      i_b[i*BW +: BW] = {4'(i), 12'(0)};
    end
    exp_b = '0;
    for (int k = 0; k < 9; k++) begin
      #1;
      exp_g = 3'(1 << (k % 3));
      check("t1_grant", i_bready, exp_g);
      if (k == 0) check("t1_first_idle", o_bvalid[0], 0);
      else begin
        check("t1_o_bvalid", o_bvalid[0], 1);
        check("t1_o_b", o_b[0 +: BW], exp_b);
      end
      exp_b = i_b[(k % 3)*BW +: BW];
      tick();
      i_b[(k % 3)*BW +: BW] = exp_b + 1'b1;
    end

    // Routing table: single beats, masking to lowest destination, sink drops.
    do_reset();
    o_bready = '1;
    merr = 0;
    for (int v = 0; v < 8; v++) begin
      idle();
      pay = 16'hA000 + 16'(v);
      i_bvalid[vecs[v].src] = 1'b1;
      bmatch[vecs[v].src*NO +: NO] = vecs[v].match;
      i_b[vecs[v].src*BW +: BW] = pay;
      #1;
      check("tbl_ready", i_bready[vecs[v].src], 1);
      tick();
      idle();
      #1;
      check("tbl_route", o_bvalid, (vecs[v].dst < 0) ? 3'b000 : 3'(1 << vecs[v].dst));
      if (vecs[v].dst >= 0) check("tbl_data", o_b[vecs[v].dst*BW +: BW], pay);
      else merr++;
      check("tbl_err_cnt", err_cnt, merr);
      tick();
    end

    // R burst from in0 locks out 1 against in2 until rlast.
    do_reset();
    o_rready = '1;
    beat = 0;
    i_rvalid[0] = 1'b1; rmatch[0 +: NO] = 3'b010; i_r[0 +: RW] = mk_r(0, 0, 0);
    i_rvalid[2] = 1'b1; rmatch[2*NO +: NO] = 3'b010; i_r[2*RW +: RW] = mk_r(2, 0, 1);
    seen.delete();
    for (int k = 0; k < 8; k++) begin
      #1;
      if (o_rvalid[1]) seen.push_back(o_r[RW +: RW]);
      if (beat < 4) check("t2_no_interleave", i_rready[2], 0);
      a0 = i_rready[0] & i_rvalid[0];
      a2 = i_rready[2] & i_rvalid[2];
      tick();
      if (a0) begin
        beat++;
        if (beat == 4) i_rvalid[0] = 1'b0;
        else i_r[0 +: RW] = mk_r(0, beat, beat == 3);
      end
      if (a2) i_rvalid[2] = 1'b0;
    end
    expq = '{mk_r(0, 0, 0), mk_r(0, 1, 0), mk_r(0, 2, 0), mk_r(0, 3, 1), mk_r(2, 0, 1)};
    check("t2_count", seen.size(), 5);
    for (int n = 0; n < 5 && n < seen.size(); n++) check("t2_order", seen[n], expq[n]);

    // Backpressure: depth 2 fills, then drains in order.
    do_reset();
    acc = 0; beat = 0;
    expq.delete();
    i_rvalid[1] = 1'b1; rmatch[NO +: NO] = 3'b100; i_r[RW +: RW] = mk_r(1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      #1;
      a0 = i_rready[1];
      if (a0) begin expq.push_back(i_r[RW +: RW]); acc++; end
      tick();
      if (a0) begin beat++; i_r[RW +: RW] = mk_r(1, beat, 1); end
    end
    check("t3_accepted", acc, 2);
    #1;
    check("t3_stall_ready", i_rready[1], 0);
    i_rvalid[1] = 1'b0;
    o_rready[2] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t3_pop_valid", o_rvalid[2], 1);
      if (k < expq.size()) check("t3_pop_data", o_r[2*RW +: RW], expq[k]);
      tick();
    end
    #1;
    check("t3_empty", o_rvalid[2], 0);

    // Unmatched sink: saturation, clear priority, dual-channel drop.
    do_reset();
    i_bvalid[1] = 1'b1; bmatch[NO +: NO] = 3'b000;
    for (int k = 0; k < 300; k++) begin
      #1;
      check("t4_sink_ready", i_bready[1], 1);
      tick();
    end
    check("t4_err_sat", err_cnt, 8'hFF);
    check("t4_sticky", err_sticky, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    i_bvalid[1] = 1'b0;
    check("t4_clr_cnt", err_cnt, 0);
    check("t4_clr_sticky", err_sticky, 0);
    tick();
    i_bvalid[0] = 1'b1; bmatch[0 +: NO] = 3'b000;
    i_rvalid[0] = 1'b1; rmatch[0 +: NO] = 3'b000;
    tick();
    idle();
    check("t4_dual_drop", err_cnt, 2);
    check("t4_dual_sticky", err_sticky, 1);

    // Reset mid-burst with full FIFOs, then a fresh burst is taken at once.
    do_reset();
    i_rvalid[0] = 1'b1; rmatch[0 +: NO] = 3'b001; i_r[0 +: RW] = mk_r(0, 1, 0);
    i_bvalid[1] = 1'b1; bmatch[NO +: NO] = 3'b010;
    for (int k = 0; k < 4; k++) tick();
    check("t6_busy_full", o_busy, 1);
    check("t6_rvalid_full", o_rvalid[0], 1);
    check("t6_bvalid_full", o_bvalid[1], 1);
    check("t6_full_ready", i_rready[0], 0);
    rst = 1'b1;
    tick();
    check("t6_rst_rvalid", o_rvalid, 0);
    check("t6_rst_bvalid", o_bvalid, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_rready", i_rready, 0);
    rst = 1'b0;
    idle();
    o_rready = '1;
    i_rvalid[2] = 1'b1; rmatch[2*NO +: NO] = 3'b001; i_r[2*RW +: RW] = mk_r(2, 7, 0);
    #1;
    check("t6_new_ready", i_rready[2], 1);
    tick();
    i_rvalid[2] = 1'b0;
    check("t6_new_valid", o_rvalid[0], 1);
    check("t6_new_data", o_r[0 +: RW], mk_r(2, 7, 0));

    // Fixed priority: in0 wins every cycle.
    do_reset();
    o_bready = '1;
    for (int i = 0; i < NI; i++) begin
      i_bvalid[i] = 1'b1;
      bmatch[i*NO +: NO] = 3'b001;
      i_b[i*BW +: BW] = {4'(i), 12'hFFF};
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t5_fp_grant", fp_i_bready, 3'b001);
      if (k > 0) check("t5_fp_out", fp_o_b[0 +: BW], {4'(0), 12'hFFF});
      tick();
    end

    random_test(3000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
